// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler feeding a paced UART transmitter.
// One byte is issued per frame slot of TX_CYCLES+GAP_CYCLES clocks.
module uart_tx_sched #(
  parameter int unsigned TX_CYCLES  = 880,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       tx_wait,
  output logic       tx_data_we,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned FRAME = TX_CYCLES + GAP_CYCLES;
  localparam int unsigned CW    = (FRAME < 4) ? 2 : $clog2(FRAME);
  // Accept cycle + ISSUE cycle + (LOAD+1) WAIT cycles make one full frame slot.
  localparam logic [CW-1:0] LOAD = CW'(FRAME - 3);

  if (FRAME < 4) begin : g_bad_frame
    $error("uart_tx_sched: TX_CYCLES+GAP_CYCLES must be at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_last_grant;
  logic [7:0]      r_tx_data;
  logic            r_grant_id;
  logic            w_grant_vld;
  logic            w_grant_sel;
  logic            w_transfer;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_sel = 1'b0;
    if (r_state == S_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_sel = ~r_last_grant;
      end else if (req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_sel = 1'b0;
      end else if (req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_sel = 1'b1;
      end
    end
  end

  assign req0_ready = w_grant_vld & ~w_grant_sel;
  assign req1_ready = w_grant_vld &  w_grant_sel;
  assign w_transfer = w_grant_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_transfer) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (!tx_wait) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LOAD;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data    <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_transfer) begin
      r_tx_data    <= w_grant_sel ? req1_data : req0_data;
      r_grant_id   <= w_grant_sel;
      r_last_grant <= w_grant_sel;
    end
  end

  // Strobe is decoded from state so an async reset removes it immediately.
  assign tx_data_we = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a timing model predicts grants and
// frame slots; issued bytes are pushed on acceptance and popped on strobe.
module tb_uart_tx_sched;

  localparam int T  = 880;
  localparam int TG = 900;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, tx_wait;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, tx_data_we, busy, grant_id;
  logic [7:0] tx_data;

  logic       g_reset;
  logic       g_req0_valid, g_req1_valid, g_tx_wait;
  logic [7:0] g_req0_data, g_req1_data;
  logic       g_req0_ready, g_req1_ready, g_we, g_busy, g_grant;
  logic [7:0] g_tx_data;

  always #5 clk = ~clk;

  uart_tx_sched u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_wait(tx_wait), .tx_data_we(tx_data_we), .tx_data(tx_data),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.TX_CYCLES(880), .GAP_CYCLES(20)) u_dut_gap (
    .clk(clk), .reset(g_reset),
    .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
    .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g_req1_ready),
    .tx_wait(g_tx_wait), .tx_data_we(g_we), .tx_data(g_tx_data),
    .busy(g_busy), .grant_id(g_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [8:0] sb[$];
  int         rise_cyc[$];
  logic [8:0] rise_dat[$];
  int         cyc = 0;
  int         m_free_at = 0;
  int         acc_cyc = 0;
  int         n_acc = 0;
  int         n_rdy1 = 0;
  int         we_run = 0;
  int         last_run = 0;
  logic       m_issue = 1'b0;
  logic       m_last = 1'b1;
  logic [8:0] m_cur = '0;
  logic       prev_we = 1'b0;

  always @(negedge clk) begin
    logic exp_idle, g0, g1;
    logic [8:0] item;
    #2;
    cyc++;
    if (reset) begin
      chk("rst_we", tx_data_we, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdy0", req0_ready, 1'b0);
      chk("rst_rdy1", req1_ready, 1'b0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_gid", grant_id, 1'b0);
      m_issue = 1'b0; m_free_at = 0; m_last = 1'b1;
      sb.delete(); prev_we = 1'b0; we_run = 0;
    end else begin
      exp_idle = !m_issue && (cyc >= m_free_at);
      chk("we", tx_data_we, m_issue);
      chk("busy", busy, !exp_idle);
      if (m_issue) chk("hold_data", {grant_id, tx_data}, m_cur);
      g0 = 1'b0; g1 = 1'b0;
      if (exp_idle) begin
        if (req0_valid && req1_valid) begin
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
        end else if (req0_valid) g0 = 1'b1;
        else if (req1_valid) g1 = 1'b1;
      end
      chk("rdy0", req0_ready, g0);
      chk("rdy1", req1_ready, g1);
      n_rdy1 += int'(req1_ready);
      if (tx_data_we && !prev_we) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          item = sb.pop_front();
          chk("sb_data", {grant_id, tx_data}, item);
        end
        chk("latency", cyc - acc_cyc, 1);
        rise_cyc.push_back(cyc);
        rise_dat.push_back({grant_id, tx_data});
      end
      if (tx_data_we) we_run++;
      else if (prev_we) begin last_run = we_run; we_run = 0; end
      prev_we = tx_data_we;
      if (m_issue && !tx_wait) begin
        m_issue = 1'b0;
        m_free_at = cyc + T - 1;
      end
      if (g0 || g1) begin
        item = {g1, g1 ? req1_data : req0_data};
        sb.push_back(item);
        m_cur = item; m_last = g1; m_issue = 1'b1;
        acc_cyc = cyc; n_acc++;
      end
    end
  end

  // Gap instance: req1 always valid, strobes one per 900-cycle slot.
  int   gcyc = 0, g_last = 0, g_nr = 0;
  logic g_prev = 1'b0, g_done = 1'b0;
  always @(negedge clk) begin
    #3;
    gcyc++;
    if (!g_reset) begin
      chk("gap_rdy0", g_req0_ready, 1'b0);
      if (g_we && !g_prev) begin
        chk("gap_data", {g_grant, g_tx_data}, {1'b1, 8'h5C});
        if (g_nr > 0) chk("gap_period", gcyc - g_last, TG);
        g_last = gcyc; g_nr++;
        if (g_nr >= 3) g_done = 1'b1;
      end
      g_prev = g_we;
    end
  end

  task automatic wait_acc(input int k, input int budget);
    int tgt = n_acc + k;
    for (int i = 0; i < budget && n_acc < tgt; i++) @(negedge clk);
    chk("tmo_acc", n_acc >= tgt, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk("tmo_idle", busy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_rises();
    rise_cyc.delete(); rise_dat.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; tx_wait = 1'b0;
    req0_data = '0; req1_data = '0;
    g_reset = 1'b1; g_req0_valid = 1'b0; g_req1_valid = 1'b1; g_tx_wait = 1'b0;
    g_req0_data = 8'hEE; g_req1_data = 8'h5C;
    repeat (3) @(negedge clk);
    reset = 1'b0; g_reset = 1'b0;

    // Single request
    clear_rises();
    req0_data = 8'hA5; req0_valid = 1'b1;
    wait_acc(1, 20);
    req0_valid = 1'b0;
    wait_idle(2000);
    chk("t1_rises", rise_dat.size(), 1);
    chk("t1_data", rise_dat[0], {1'b0, 8'hA5});

    // Tie after reset: round-robin starting with requester 0
    pulse_reset();
    clear_rises();
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(4, 5000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(2000);
    chk("tie_rises", rise_dat.size(), 4);
    chk("tie_d0", rise_dat[0], {1'b0, 8'h11});
    chk("tie_d1", rise_dat[1], {1'b1, 8'h22});
    chk("tie_d2", rise_dat[2], {1'b0, 8'h11});
    chk("tie_d3", rise_dat[3], {1'b1, 8'h22});
    for (int i = 1; i < 4; i++) chk("tie_period", rise_cyc[i] - rise_cyc[i-1], T);

    // Backpressure: 5 cycles of tx_wait during ISSUE
    clear_rises();
    req0_data = 8'h3C; req0_valid = 1'b1;
    wait_acc(1, 20);
    req0_valid = 1'b0; tx_wait = 1'b1;
    repeat (5) @(negedge clk);
    tx_wait = 1'b0;
    wait_idle(2000);
    chk("bp_we_run", last_run, 6);
    chk("bp_data", rise_dat[0], {1'b0, 8'h3C});

    // Withdrawn request during WAIT leaves last_grant alone
    clear_rises();
    req0_data = 8'h77; req0_valid = 1'b1;
    wait_acc(1, 20);
    req0_valid = 1'b0;
    repeat (100) @(negedge clk);
    base = n_rdy1;
    req1_data = 8'h99; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    chk("wd_no_rdy1", n_rdy1 - base, 0);
    wait_idle(2000);
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(2, 3000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(2000);
    chk("wd_rises", rise_dat.size(), 3);
    chk("wd_d1", rise_dat[1], {1'b1, 8'h99});
    chk("wd_d2", rise_dat[2], {1'b0, 8'h77});

    // Reset in WAIT with counter at 400, pending request accepted on release
    clear_rises();
    req0_data = 8'hE1; req0_valid = 1'b1;
    wait_acc(1, 20);
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && rise_cyc.size() == 0; i++) @(negedge clk);
    chk("mr_rise", rise_cyc.size(), 1);
    repeat (477) @(negedge clk);
    req1_data = 8'h3B; req1_valid = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("mr_busy_now", busy, 1'b0);
    chk("mr_we_now", tx_data_we, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = n_acc;
    @(negedge clk);
    chk("mr_resume_acc", n_acc - base, 1);
    req1_valid = 1'b0;
    wait_idle(2000);
    chk("mr_rises", rise_dat.size(), 2);
    chk("mr_data", rise_dat[1], {1'b1, 8'h3B});

    for (int i = 0; i < 5000 && !g_done; i++) @(negedge clk);
    chk("gap_done", g_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
